// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: decodes instr_in, drives register file read
// addresses, detects load-use hazards and owns the ID/EX pipeline register.
module decode_stage #(
   parameter int unsigned XLEN      = 32,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     instr_in,
   input  logic [XLEN-1:0] pc_in,
   input  logic            if_valid,
   input  logic            ex_stall,
   input  logic            flush,
   output logic [4:0]      Read_Reg1,
   output logic [4:0]      Read_Reg2,
   output logic            id_ready,
   output logic            id_ex_valid,
   output logic [31:0]     id_ex_instr,
   output logic [XLEN-1:0] id_ex_pc,
   output logic [XLEN-1:0] id_ex_imm,
   output logic [4:0]      id_ex_rs1,
   output logic [4:0]      id_ex_rs2,
   output logic [4:0]      id_ex_rd,
   output logic [3:0]      id_ex_alu_op,
   output logic            id_ex_alu_src,
   output logic            id_ex_RegWrite,
   output logic            id_ex_MemRead,
   output logic            id_ex_MemWrite,
   output logic            id_ex_Branch,
   output logic            id_ex_Jump,
   output logic [2:0]      id_ex_funct3,
   output logic            id_ex_illegal
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_SLL    = 4'd2;
   localparam logic [3:0] ALU_SLT    = 4'd3;
   localparam logic [3:0] ALU_SLTU   = 4'd4;
   localparam logic [3:0] ALU_XOR    = 4'd5;
   localparam logic [3:0] ALU_SRL    = 4'd6;
   localparam logic [3:0] ALU_SRA    = 4'd7;
   localparam logic [3:0] ALU_OR     = 4'd8;
   localparam logic [3:0] ALU_AND    = 4'd9;
   localparam logic [3:0] ALU_PASS_B = 4'd10;

   typedef struct packed {
      logic            valid;
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [3:0]      alu_op;
      logic            alu_src;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            branch;
      logic            jump;
      logic [2:0]      funct3;
      logic            illegal;
   } id_ex_t;

   localparam id_ex_t BUBBLE = '{instr: NOP_INSTR, default: '0};

   id_ex_t      q;
   id_ex_t      nxt;
   id_ex_t      dec;
   logic [31:0] imm32;
   logic        rs1_used;
   logic        rs2_used;
   logic        hazard;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode = instr_in[6:0];
   assign funct3 = instr_in[14:12];
   assign imm_i  = {{20{instr_in[31]}}, instr_in[31:20]};
   assign imm_s  = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
   assign imm_b  = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25],
                    instr_in[11:8], 1'b0};
   assign imm_u  = {instr_in[31:12], 12'b0};
   assign imm_j  = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20],
                    instr_in[30:21], 1'b0};

   function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
      logic [3:0] op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   // Instruction decode into an ID/EX payload
   always_comb begin
      dec        = '0;
      imm32      = '0;
      dec.valid  = 1'b1;
      dec.instr  = instr_in;
      dec.pc     = pc_in;
      dec.rs1    = instr_in[19:15];
      dec.rs2    = instr_in[24:20];
      dec.rd     = instr_in[11:7];
      dec.funct3 = funct3;
      case (opcode)
         OPC_LUI: begin
            imm32         = imm_u;
            dec.alu_op    = ALU_PASS_B;
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
         end
         OPC_AUIPC: begin
            imm32         = imm_u;
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
         end
         OPC_JAL: begin
            imm32         = imm_j;
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            dec.jump      = 1'b1;
         end
         OPC_JALR: begin
            imm32         = imm_i;
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            dec.jump      = 1'b1;
         end
         OPC_BRANCH: begin
            imm32      = imm_b;
            dec.alu_op = ALU_SUB;
            dec.branch = 1'b1;
         end
         OPC_LOAD: begin
            imm32         = imm_i;
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            dec.mem_read  = 1'b1;
         end
         OPC_STORE: begin
            imm32         = imm_s;
            dec.alu_src   = 1'b1;
            dec.mem_write = 1'b1;
         end
         OPC_OP_IMM: begin
            imm32         = imm_i;
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_op    = alu_fn(funct3, instr_in[30] & (funct3 == 3'b101));
         end
         OPC_OP: begin
            dec.reg_write = 1'b1;
            dec.alu_op    = alu_fn(funct3, instr_in[30]);
         end
         default: dec.illegal = 1'b1;
      endcase
      dec.imm = XLEN'($signed(imm32));
      if (dec.rd == 5'd0) dec.reg_write = 1'b0;
   end

   // Load-use hazard against the load currently in ID/EX
   always_comb begin
      rs1_used = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
      rs2_used = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
      hazard   = q.valid & q.mem_read & (q.rd != 5'd0) & if_valid &
                 ((rs1_used & (q.rd == instr_in[19:15])) |
                  (rs2_used & (q.rd == instr_in[24:20])));
   end

   // While stalled, re-read the held instruction's operands
   assign Read_Reg1 = ex_stall ? q.rs1 : instr_in[19:15];
   assign Read_Reg2 = ex_stall ? q.rs2 : instr_in[24:20];
   assign id_ready  = ~ex_stall & ~hazard;

   always_comb begin
      nxt = q;
      if (flush)                  nxt = BUBBLE;
      else if (ex_stall)          nxt = q;
      else if (hazard || !if_valid) nxt = BUBBLE;
      else                        nxt = dec;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) q <= BUBBLE;
      else        q <= nxt;
   end

   assign id_ex_valid    = q.valid;
   assign id_ex_instr    = q.instr;
   assign id_ex_pc       = q.pc;
   assign id_ex_imm      = q.imm;
   assign id_ex_rs1      = q.rs1;
   assign id_ex_rs2      = q.rs2;
   assign id_ex_rd       = q.rd;
   assign id_ex_alu_op   = q.alu_op;
   assign id_ex_alu_src  = q.alu_src;
   assign id_ex_RegWrite = q.reg_write;
   assign id_ex_MemRead  = q.mem_read;
   assign id_ex_MemWrite = q.mem_write;
   assign id_ex_Branch   = q.branch;
   assign id_ex_Jump     = q.jump;
   assign id_ex_funct3   = q.funct3;
   assign id_ex_illegal  = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: instruction-level reference model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_decode_stage;

   logic        clk;
   logic        reset;
   logic [31:0] instr_in;
   logic [31:0] pc_in;
   logic        if_valid;
   logic        ex_stall;
   logic        flush;
   logic [4:0]  Read_Reg1, Read_Reg2;
   logic        id_ready;
   logic        id_ex_valid;
   logic [31:0] id_ex_instr, id_ex_pc, id_ex_imm;
   logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
   logic [3:0]  id_ex_alu_op;
   logic        id_ex_alu_src, id_ex_RegWrite, id_ex_MemRead, id_ex_MemWrite;
   logic        id_ex_Branch, id_ex_Jump, id_ex_illegal;
   logic [2:0]  id_ex_funct3;

   decode_stage dut (
      .clk(clk), .reset(reset), .instr_in(instr_in), .pc_in(pc_in),
      .if_valid(if_valid), .ex_stall(ex_stall), .flush(flush),
      .Read_Reg1(Read_Reg1), .Read_Reg2(Read_Reg2), .id_ready(id_ready),
      .id_ex_valid(id_ex_valid), .id_ex_instr(id_ex_instr), .id_ex_pc(id_ex_pc),
      .id_ex_imm(id_ex_imm), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
      .id_ex_rd(id_ex_rd), .id_ex_alu_op(id_ex_alu_op), .id_ex_alu_src(id_ex_alu_src),
      .id_ex_RegWrite(id_ex_RegWrite), .id_ex_MemRead(id_ex_MemRead),
      .id_ex_MemWrite(id_ex_MemWrite), .id_ex_Branch(id_ex_Branch),
      .id_ex_Jump(id_ex_Jump), .id_ex_funct3(id_ex_funct3), .id_ex_illegal(id_ex_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit run   = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   typedef struct {
      logic        valid;
      logic [31:0] instr, pc, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [3:0]  alu_op;
      logic        alu_src, rw, mr, mw, br, jp, ill;
      logic [2:0]  f3;
   } st_t;

   function automatic st_t m_bubble();
      st_t e;
      e = '{default: '0};
      e.instr = 32'h0000_0013;
      return e;
   endfunction

   function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
      int base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
      if (alt && f3 == 3'd0) return 4'd1;
      if (alt && f3 == 3'd5) return 4'd7;
      return 4'(base[f3]);
   endfunction

   // Reference decode using arithmetic assembly of the immediates
   function automatic st_t m_decode(input logic [31:0] ins, input logic [31:0] pc);
      st_t e;
      int  si;
      e  = m_bubble();
      si = int'($signed(ins));
      e.valid = 1'b1; e.instr = ins; e.pc = pc;
      e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.f3 = ins[14:12];
      case (ins[6:0])
         7'h37: begin e.imm = ins & 32'hFFFF_F000; e.alu_op = 4'd10; e.alu_src = 1; e.rw = 1; end
         7'h17: begin e.imm = ins & 32'hFFFF_F000; e.alu_src = 1; e.rw = 1; end
         7'h6F: begin
            e.imm = 32'((ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 +
                        int'(ins[20]) * 2048 + int'(ins[30:21]) * 2);
            e.alu_src = 1; e.rw = 1; e.jp = 1;
         end
         7'h67: begin e.imm = 32'(si >>> 20); e.alu_src = 1; e.rw = 1; e.jp = 1; end
         7'h63: begin
            e.imm = 32'((ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 +
                        int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2);
            e.alu_op = 4'd1; e.br = 1;
         end
         7'h03: begin e.imm = 32'(si >>> 20); e.alu_src = 1; e.rw = 1; e.mr = 1; end
         7'h23: begin e.imm = 32'((si >>> 25) * 32 + int'(ins[11:7])); e.alu_src = 1; e.mw = 1; end
         7'h13: begin
            e.imm = 32'(si >>> 20); e.alu_src = 1; e.rw = 1;
            e.alu_op = alu_of(ins[14:12], ins[30] && ins[14:12] == 3'd5);
         end
         7'h33: begin e.rw = 1; e.alu_op = alu_of(ins[14:12], ins[30]); end
         default: e.ill = 1'b1;
      endcase
      if (e.rd == 5'd0) e.rw = 1'b0;
      return e;
   endfunction

   function automatic bit m_haz(input logic [31:0] ins, input logic v, input st_t e);
      bit u1, u2;
      if (!(e.valid && e.mr && e.rd != 5'd0 && v)) return 1'b0;
      u1 = !(ins[6:0] inside {7'h37, 7'h17, 7'h6F});
      u2 = ins[6:0] inside {7'h33, 7'h23, 7'h63};
      return (u1 && ins[19:15] == e.rd) || (u2 && ins[24:20] == e.rd);
   endfunction

   function automatic st_t m_next(input st_t e, input logic [31:0] ins, input logic [31:0] pc,
                                  input logic v, input logic st, input logic fl);
      if (fl) return m_bubble();
      if (st) return e;
      if (m_haz(ins, v, e) || !v) return m_bubble();
      return m_decode(ins, pc);
   endfunction

   st_t m;

   always @(posedge clk or negedge reset) begin
      if (!reset) m <= m_bubble();
      else        m <= m_next(m, instr_in, pc_in, if_valid, ex_stall, flush);
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (run) begin
         chk("valid",    32'(id_ex_valid),    32'(m.valid));
         chk("instr",    id_ex_instr,         m.instr);
         chk("pc",       id_ex_pc,            m.pc);
         chk("imm",      id_ex_imm,           m.imm);
         chk("rs1",      32'(id_ex_rs1),      32'(m.rs1));
         chk("rs2",      32'(id_ex_rs2),      32'(m.rs2));
         chk("rd",       32'(id_ex_rd),       32'(m.rd));
         chk("alu_op",   32'(id_ex_alu_op),   32'(m.alu_op));
         chk("alu_src",  32'(id_ex_alu_src),  32'(m.alu_src));
         chk("RegWrite", 32'(id_ex_RegWrite), 32'(m.rw));
         chk("MemRead",  32'(id_ex_MemRead),  32'(m.mr));
         chk("MemWrite", 32'(id_ex_MemWrite), 32'(m.mw));
         chk("Branch",   32'(id_ex_Branch),   32'(m.br));
         chk("Jump",     32'(id_ex_Jump),     32'(m.jp));
         chk("funct3",   32'(id_ex_funct3),   32'(m.f3));
         chk("illegal",  32'(id_ex_illegal),  32'(m.ill));
         chk("Read_Reg1", 32'(Read_Reg1), 32'(ex_stall ? m.rs1 : instr_in[19:15]));
         chk("Read_Reg2", 32'(Read_Reg2), 32'(ex_stall ? m.rs2 : instr_in[24:20]));
         chk("id_ready", 32'(id_ready),
             32'(!ex_stall && !m_haz(instr_in, if_valid, m)));
      end
   end

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                        input logic st, input logic fl);
      @(posedge clk);
      #2;
      instr_in = ins; pc_in = pc; if_valid = v; ex_stall = st; flush = fl;
   endtask

   logic [31:0] tbl_ins [8] = '{32'h402081B3, 32'h4030D213, 32'hC0008093, 32'h001000EF,
                                32'hFE321F23, 32'h12345517, 32'h00028437, 32'h0020B2B3};
   logic [31:0] tbl_imm [8] = '{32'h0, 32'h403, 32'hFFFFFC00, 32'h800,
                                32'hFFFFFFFE, 32'h12345000, 32'h00028000, 32'h0};
   logic [3:0]  tbl_aop [8] = '{4'd1, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd10, 4'd4};

   logic [31:0] pool [16] = '{32'h0000A283, 32'h00728333, 32'h00512023, 32'h00028437,
                              32'h402081B3, 32'h4020D233, 32'h0020A2B3, 32'h0020C2B3,
                              32'h0020E2B3, 32'h0020F2B3, 32'h002092B3, 32'h0030D213,
                              32'hFFDFF0EF, 32'h004100E7, 32'h00209463, 32'hFFFFFFFF};

   initial begin
      reset = 1'b1; instr_in = 32'h13; pc_in = '0; if_valid = 0; ex_stall = 0; flush = 0;
      #1 reset = 1'b0;
      run = 1'b1;

      // Reset held with random inputs
      for (int i = 0; i < 3; i++) begin
         drive($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
         @(negedge clk);
         chk("rst_valid", 32'(id_ex_valid), 32'h0);
         chk("rst_instr", id_ex_instr, 32'h13);
         chk("rst_imm", id_ex_imm, 32'h0);
      end
      @(posedge clk); #2;
      reset = 1'b1; if_valid = 0; ex_stall = 0; flush = 0;
      @(negedge clk);
      chk("rel_valid", 32'(id_ex_valid), 32'h0);
      drive(32'h0, 32'h0, 0, 0, 0);
      @(negedge clk);
      chk("rel_regwrite", 32'(id_ex_RegWrite), 32'h0);

      // addi x1,x2,5 then beq x0,x0,-4
      drive(32'h00510093, 32'h100, 1, 0, 0);
      @(negedge clk);
      chk("addi_rr1", 32'(Read_Reg1), 32'd2);
      drive(32'hFE000EE3, 32'h104, 1, 0, 0);
      @(negedge clk);
      chk("addi_imm", id_ex_imm, 32'd5);
      chk("addi_rd", 32'(id_ex_rd), 32'd1);
      chk("addi_aop", 32'(id_ex_alu_op), 32'd0);
      chk("addi_src", 32'(id_ex_alu_src), 32'd1);
      chk("addi_rw", 32'(id_ex_RegWrite), 32'd1);
      chk("addi_pc", id_ex_pc, 32'h100);
      chk("addi_valid", 32'(id_ex_valid), 32'd1);
      drive(32'h13, 32'h108, 0, 0, 0);
      @(negedge clk);
      chk("beq_imm", id_ex_imm, 32'hFFFFFFFC);
      chk("beq_br", 32'(id_ex_Branch), 32'd1);
      chk("beq_rw", 32'(id_ex_RegWrite), 32'd0);
      chk("beq_aop", 32'(id_ex_alu_op), 32'd1);

      // Load-use: lw x5 then add x6,x5,x7
      drive(32'h0000A283, 32'h200, 1, 0, 0);
      drive(32'h00728333, 32'h204, 1, 0, 0);
      @(negedge clk);
      chk("lu_ready", 32'(id_ready), 32'd0);
      chk("lu_memread", 32'(id_ex_MemRead), 32'd1);
      drive(32'h00728333, 32'h204, 1, 0, 0);
      @(negedge clk);
      chk("lu_bubble", 32'(id_ex_valid), 32'd0);
      chk("lu_ready2", 32'(id_ready), 32'd1);
      drive(32'h13, 32'h208, 0, 0, 0);
      @(negedge clk);
      chk("lu_rs1", 32'(id_ex_rs1), 32'd5);
      chk("lu_rs2", 32'(id_ex_rs2), 32'd7);
      chk("lu_pc", id_ex_pc, 32'h204);
      chk("lu_issue", 32'(id_ex_valid), 32'd1);

      // lw x5 then lui (rs1 field 5, unused) and sw x5 (rs2 used)
      drive(32'h0000A283, 32'h210, 1, 0, 0);
      drive(32'h00028437, 32'h214, 1, 0, 0);
      @(negedge clk);
      chk("lui_noharz", 32'(id_ready), 32'd1);
      drive(32'h0000A283, 32'h218, 1, 0, 0);
      drive(32'h00512023, 32'h21C, 1, 0, 0);
      @(negedge clk);
      chk("sw_haz", 32'(id_ready), 32'd0);
      drive(32'h00512023, 32'h21C, 1, 0, 0);

      // Downstream stall for 3 cycles, then flush while stalled
      drive(32'h00510093, 32'h300, 1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         drive(32'h00728333, 32'h304, 1, 1, 0);
         @(negedge clk);
         chk("stall_rr1", 32'(Read_Reg1), 32'd2);
         chk("stall_rr2", 32'(Read_Reg2), 32'd5);
         chk("stall_pc", id_ex_pc, 32'h300);
         chk("stall_ready", 32'(id_ready), 32'd0);
      end
      drive(32'h00728333, 32'h304, 1, 1, 1);
      drive(32'h00728333, 32'h304, 1, 0, 0);
      @(negedge clk);
      chk("flush_valid", 32'(id_ex_valid), 32'd0);
      chk("flush_instr", id_ex_instr, 32'h13);

      // Illegal opcode, then add x0,x1,x2
      drive(32'hFFFFFFFF, 32'h400, 1, 0, 0);
      drive(32'h00208033, 32'h404, 1, 0, 0);
      @(negedge clk);
      chk("ill_flag", 32'(id_ex_illegal), 32'd1);
      chk("ill_rw", 32'(id_ex_RegWrite), 32'd0);
      chk("ill_src", 32'(id_ex_alu_src), 32'd0);
      chk("ill_valid", 32'(id_ex_valid), 32'd1);
      drive(32'h13, 32'h408, 0, 0, 0);
      @(negedge clk);
      chk("x0_rw", 32'(id_ex_RegWrite), 32'd0);
      chk("x0_ill", 32'(id_ex_illegal), 32'd0);

      // Immediate formats and ALU op selection
      for (int i = 0; i < 8; i++) begin
         drive(tbl_ins[i], 32'h500 + 32'(i * 4), 1, 0, 0);
         drive(32'h13, 32'h0, 0, 0, 0);
         @(negedge clk);
         chk("tbl_imm", id_ex_imm, tbl_imm[i]);
         chk("tbl_aop", 32'(id_ex_alu_op), 32'(tbl_aop[i]));
      end

      // Reset asserted mid-hazard
      drive(32'h0000A283, 32'h600, 1, 0, 0);
      drive(32'h00728333, 32'h604, 1, 0, 0);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", 32'(id_ex_valid), 32'd0);
      chk("mid_rst_ready", 32'(id_ready), 32'd1);
      @(posedge clk); #2 reset = 1'b1;
      drive(32'h13, 32'h608, 0, 0, 0);
      @(negedge clk);
      chk("post_rst_valid", 32'(id_ex_valid), 32'd1);
      chk("post_rst_rd", 32'(id_ex_rd), 32'd6);

      // Random mix from the instruction pool
      for (int i = 0; i < 60; i++) begin
         drive(pool[$urandom_range(0, 15)], $urandom, $urandom_range(0, 3) != 0,
               $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
      end
      drive(32'h13, 32'h0, 0, 0, 0);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Instruction-decode stage of the RV32I pipeline, directly upstream of the register file. Decodes the fetched instruction and drives the register file read addresses, then registers control, immediate, PC and register indices into the ID/EX pipeline register. Those registered outputs arrive in the same cycle as the register file's registered Data_out1/Data_out2. Also owns load-use hazard detection, bubble insertion and flush.

Parameters:
XLEN, 32, datapath width (PC, immediate)
NOP_INSTR, 32'h0000_0013, encoding reported on id_ex_instr for bubbles

Ports:
clk  input  1  pipeline clock
reset  input  1  asynchronous, active-low reset
instr_in  input  32  instruction from IF/ID
pc_in  input  XLEN  PC of instr_in
if_valid  input  1  instr_in valid
ex_stall  input  1  downstream cannot accept; hold ID/EX
flush  input  1  branch/jump redirect; kill the decoding instruction
Read_Reg1  output  5  register file rs1 address (combinational)
Read_Reg2  output  5  register file rs2 address (combinational)
id_ready  output  1  instr_in consumed this cycle (combinational)
id_ex_valid  output  1  ID/EX holds a real instruction
id_ex_pc  output  XLEN  registered PC
id_ex_imm  output  XLEN  registered sign-extended immediate
id_ex_rs1, id_ex_rs2, id_ex_rd  output  5 each  registered indices, for forwarding
id_ex_alu_op  output  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B
id_ex_alu_src  output  1  1 = operand B is the immediate
id_ex_RegWrite, id_ex_MemRead, id_ex_MemWrite, id_ex_Branch, id_ex_Jump  output  1 each  controls
id_ex_funct3  output  3  branch and load/store size
id_ex_illegal  output  1  unrecognised opcode was decoded

Behaviour:
- Reset (reset=0, asynchronous):
  - All id_ex_* outputs are 0, except id_ex_instr, which is NOP_INSTR.
  - The bubble state is id_ex_valid=0 with every control bit 0.
- Decode (combinational):
  - Opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - Immediate formats: I, S, B, U, J, all sign-extended to XLEN.
  - LUI produces alu_op=PASS_B.
  - funct7[5] selects SUB for OP, and SRA for both OP and OP-IMM.
  - Any other opcode gives illegal=1 with all controls forced to 0.
  - RegWrite is forced to 0 when rd=0.
- Read address mux:
  - When ex_stall=1, Read_Reg1/2 = id_ex_rs1/rs2. The register file re-reads the held instruction's operands, so its registered outputs stay aligned with ID/EX.
  - Otherwise Read_Reg1/2 = instr_in[19:15] and instr_in[24:20].
- Load-use hazard:
  - hazard = id_ex_valid & id_ex_MemRead & id_ex_rd≠0 & if_valid & (id_ex_rd==rs1 used, or id_ex_rd==rs2 used).
  - rs2 counts as used only for OP, STORE and BRANCH.
  - rs1 counts as unused for LUI, AUIPC and JAL.
- id_ready = ~ex_stall & ~hazard.
- ID/EX update on posedge clk, priority order:
  1. flush=1: load a bubble, even if ex_stall=1.
  2. ex_stall=1: hold every field.
  3. hazard=1: load a bubble. Upstream holds instr_in because id_ready=0.
  4. Otherwise: load the decoded instr_in, with id_ex_valid=if_valid. When if_valid=0, all controls are 0.
- Latency: exactly 1 cycle from instr_in to id_ex_*.
- A hazard bubble lasts exactly one cycle. The stalled instruction issues the following cycle; the register file's negedge write makes the loaded value visible by then.
- Reset asserted mid-stall or mid-hazard: state clears immediately and no stall persists after release.

Test Plan:
- Reset: hold reset=0 with random inputs → all id_ex_* are 0 and id_ex_valid=0; after release with if_valid=0 they stay 0.
- Decode of addi x1,x2,5 (0x00510093, pc 0x100): expect Read_Reg1=2 that cycle. Next cycle expect imm=5, rd=1, alu_op=0, alu_src=1, RegWrite=1, pc=0x100, valid=1.
- Decode of beq x0,x0,-4 (0xFE000EE3): expect imm=0xFFFFFFFC, Branch=1, RegWrite=0, alu_op=SUB.
- Load-use: lw x5,0(x1) (0x0000A283) followed by add x6,x5,x7 (0x00728333):
  - Second cycle: id_ready=0, and the ID/EX bubble carries valid=0.
  - Third cycle: the add issues with rs1=5, rs2=7; no further stall.
- Downstream stall then flush: hold ex_stall=1 for 3 cycles → ID/EX is unchanged and Read_Reg1/2 equal id_ex_rs1/rs2. Then assert flush with ex_stall=1 → next edge loads a bubble.
- Illegal and x0 cases:
  - Opcode 7'b1111111 → illegal=1 with all controls 0.
  - add x0,x1,x2 → RegWrite=0.
